dual_port_ram_ctrl: RTL
=======================

Name: dual_port_ram_ctrl

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 256x8 byte RAM.
- Adds configurable width/depth, per-port req/ready handshake, read-valid pipeline with selectable latency, and defined collision rules.
- Adds a hardware clear engine that zero-fills the array after reset or on request.
- Sits between the CPU datapath (port 1, load/store) and fetch/DMA (port 2).

Parameters:
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
DATA_W, 8, word width in bits
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (any other value is an elaboration error)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous active-high reset
en  input  1  global enable; when low both ready outputs are 0 and no operation is accepted
clear  input  1  single-cycle pulse; starts a zero-fill of the whole array
busy  output  1  high while the clear engine runs
req_1  input  1  port 1 request
we_1  input  1  port 1: 1 write, 0 read
addr_1  input  ADDR_W  port 1 address
wdata_1  input  DATA_W  port 1 write data
ready_1  output  1  port 1 may accept; an access is taken when req_1 & ready_1
rdata_1  output  DATA_W  port 1 read data
rvalid_1  output  1  port 1 read data valid, one-cycle pulse
req_2, we_2, addr_2, wdata_2, ready_2, rdata_2, rvalid_2: same as port 1, for port 2

Behaviour:
- Reset (async assert, sync release): state CLEAR, clear counter = 0, busy = 1, ready_x = 0, rvalid_x = 0, rdata_x = 0, read pipelines flushed.
- FSM states:
  - CLEAR: writes 0 to address = counter each cycle; counter increments.
  - CLEAR exits to IDLE after address DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
  - Counter is ADDR_W+1 bits so terminal detection does not wrap.
  - IDLE: ready_x = en & ~busy (combinational from state and en).
  - A clear pulse in IDLE goes to CLEAR next cycle with counter = 0.
  - A clear pulse during CLEAR restarts the counter at 0.
- Accepted write: array updated at the accepting edge.
- Accepted read:
  - rdata_x and rvalid_x appear RD_LAT cycles after the accepting edge.
  - RD_LAT=1: registered output. RD_LAT=2: one extra output register stage.
  - rvalid_x pulses for one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
  - rdata_x holds its last value while rvalid_x = 0.
- Same-port read-during-write is impossible (one op per port per cycle).
- Cross-port collisions, same address, same cycle:
  - Both write: port 1 data wins.
  - One reads, the other writes: read returns OLD data (read-first); the write still lands.
- Reads in flight when clear is asserted still complete with pre-clear data.
- Reset mid-CLEAR restarts clear from address 0; array contents are undefined until the clear finishes.
- en low mid-stream:
  - No new accepts.
  - In-flight read pipeline keeps advancing, so rvalid still fires.
  - The clear engine keeps running regardless of en.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - Array is DATA_W+1 bits wide; the extra bit is even parity of wdata, computed on write.
  - Clear writes parity 0.
  - Extra outputs perr_1 and perr_2 (1 bit each), aligned with rvalid_x.
  - perr_x is high when stored parity ≠ XOR of read data.
  - perr_x resets to 0.
- Undefined: array is DATA_W wide; no perr ports exist.

Test Plan:
- Reset, then hold en=1 with no requests, DEPTH=256 -> busy=1 and ready_x=0 for exactly 256 cycles, then ready_1=ready_2=1; read of addr 0x5A -> rdata 0x00.
- Port 1 writes 0xA5 to 0x10; next cycle port 2 reads 0x10 -> rvalid_2 pulses RD_LAT cycles later with rdata_2 = 0xA5; repeat with RD_LAT=2 to check the extra cycle.
- Same cycle: port 1 writes 0x11 and port 2 writes 0x22 to 0x30; then read 0x30 -> 0x11.
- 0x40 holds 0x7E; same cycle: port 1 writes 0x33 to 0x40 and port 2 reads 0x40 -> rdata_2 = 0x7E; a later read -> 0x33.
- Pulse clear at cycle 100 of a 256-cycle clear, then async reset at cycle 50 of the new clear -> busy stays high; ready rises exactly 256 cycles after reset release; all words read 0.
- Four back-to-back port 1 reads of 0x01..0x04 with en dropped after the third accept -> exactly three rvalid_1 pulses with the correct data; the fourth request is not accepted (ready_1 = 0).

Source files
------------

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port synchronous RAM with req/ready handshake, RD_LAT-cycle read pipeline and zero-fill clear engine.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose perr_1/perr_2.
module dual_port_ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    output logic              busy,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ready_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              rvalid_1,
    input  logic              req_2,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              ready_2,
    output logic [DATA_W-1:0] rdata_2,
    output logic              rvalid_2
`ifdef RAM_PARITY_EN
    ,
    output logic              perr_1,
    output logic              perr_2
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_reg;
    logic [ADDR_W:0]   clr_cnt_reg;
    logic              port_ready;

    logic [1:0]              req_p;
    logic [1:0]              we_p;
    logic [1:0]              acc_rd;
    logic [1:0]              acc_wr;
    logic [1:0][ADDR_W-1:0]  addr_p;
    logic [1:0][DATA_W-1:0]  wdata_p;
    logic [1:0][MEM_W-1:0]   wword_p;
    logic [1:0]              out_valid_p;
    logic [1:0][MEM_W-1:0]   out_word_p;

    logic [MEM_W-1:0] mem [DEPTH];

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("dual_port_ram_ctrl: RD_LAT must be 1 or 2");
        end
    endgenerate

    // Clear engine: one word per cycle, exits after writing DEPTH-1; clear restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (clear) begin
                        clr_cnt_reg <= '0;
                    end else if (clr_cnt_reg == CNT_LAST) begin
                        state_reg   <= ST_IDLE;
                        clr_cnt_reg <= '0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    if (clear) begin
                        state_reg   <= ST_CLEAR;
                        clr_cnt_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign busy       = (state_reg == ST_CLEAR);
    assign port_ready = en & ~busy;
    assign ready_1    = port_ready;
    assign ready_2    = port_ready;

    assign req_p   = {req_2, req_1};
    assign we_p    = {we_2, we_1};
    assign addr_p  = {addr_2, addr_1};
    assign wdata_p = {wdata_2, wdata_1};
    assign acc_wr  = req_p & we_p & {2{port_ready}};
    assign acc_rd  = req_p & ~we_p & {2{port_ready}};

    // Port 1 write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt_reg[ADDR_W-1:0]] <= '0;
        end else begin
            if (acc_wr[1]) mem[addr_p[1]] <= wword_p[1];
            if (acc_wr[0]) mem[addr_p[0]] <= wword_p[0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic             s1_valid_reg;
            logic [MEM_W-1:0] s1_word_reg;

`ifdef RAM_PARITY_EN
            assign wword_p[gi] = {^wdata_p[gi], wdata_p[gi]};
`else
            assign wword_p[gi] = wdata_p[gi];
`endif

            // Nonblocking read of mem gives read-first behaviour against the other port's write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_reg <= 1'b0;
                    s1_word_reg  <= '0;
                end else begin
                    s1_valid_reg <= acc_rd[gi];
                    if (acc_rd[gi]) s1_word_reg <= mem[addr_p[gi]];
                end
            end

            if (RD_LAT == 2) begin : g_lat2
                logic             s2_valid_reg;
                logic [MEM_W-1:0] s2_word_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s2_valid_reg <= 1'b0;
                        s2_word_reg  <= '0;
                    end else begin
                        s2_valid_reg <= s1_valid_reg;
                        if (s1_valid_reg) s2_word_reg <= s1_word_reg;
                    end
                end

                assign out_valid_p[gi] = s2_valid_reg;
                assign out_word_p[gi]  = s2_word_reg;
            end else begin : g_lat1
                assign out_valid_p[gi] = s1_valid_reg;
                assign out_word_p[gi]  = s1_word_reg;
            end
        end
    endgenerate

    assign rdata_1  = out_word_p[0][DATA_W-1:0];
    assign rvalid_1 = out_valid_p[0];
    assign rdata_2  = out_word_p[1][DATA_W-1:0];
    assign rvalid_2 = out_valid_p[1];

`ifdef RAM_PARITY_EN
    assign perr_1 = out_valid_p[0] & (out_word_p[0][DATA_W] ^ (^out_word_p[0][DATA_W-1:0]));
    assign perr_2 = out_valid_p[1] & (out_word_p[1][DATA_W] ^ (^out_word_p[1][DATA_W-1:0]));
`endif

endmodule
